wb_drain: RTL and testbench

Writeback drain buffer. It is the consumer of the writeback-stage hold path: it accepts completed writebacks (GPR and CSR) from the WB stage. While the register-file/CSR write ports are blocked, it queues them in order. Once the block clears, it replays them to the register file and CSR file, one per cycle. It also forwards the youngest pending GPR value to decode so that held results are never invisible to younger instructions.

---
 rtl/wb_drain.sv | 147 ++++++++++++++
 tb/tb_wb_drain.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/wb_drain.sv
// Writeback drain buffer. Holds completed GPR/CSR writebacks while the write
// ports are blocked, replays them in program order once unblocked, and
// forwards the youngest pending GPR value to decode.
module wb_drain #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_valid,
    input  logic [4:0]  wb_rd,
    input  logic        wb_rd_we,
    input  logic [63:0] wb_data,
    input  logic        wb_csr_we,
    input  logic [11:0] wb_csr_addr,
    input  logic [63:0] wb_csr_data,
    input  logic        block,
    output logic        rf_we,
    output logic [4:0]  rf_addr,
    output logic [63:0] rf_wdata,
    output logic        csr_we,
    output logic [11:0] csr_addr,
    output logic [63:0] csr_wdata,
    input  logic [4:0]  rs1_addr,
    input  logic [4:0]  rs2_addr,
    output logic        rs1_hit,
    output logic        rs2_hit,
    output logic [63:0] rs1_data,
    output logic [63:0] rs2_data,
    output logic        full,
    output logic        empty,
    output logic        overflow
);

    localparam int PW = $clog2(DEPTH);

    typedef struct packed {
        logic [4:0]  rd;
        logic        rd_we;
        logic [63:0] data;
        logic        csr_we;
        logic [11:0] csr_addr;
        logic [63:0] csr_data;
    } entry_t;

    entry_t            mem [DEPTH];
    logic [DEPTH-1:0]  vld;
    logic [PW-1:0]     head, tail;
    logic [PW:0]       count;
    logic              ovf_q;

    entry_t            in_e;
    logic              useful, enq, deq;

    // Normalise the incoming writeback; x0 targets lose their GPR enable.
    always_comb begin
        in_e          = '0;
        in_e.rd       = wb_rd;
        in_e.rd_we    = wb_rd_we && (wb_rd != 5'd0);
        in_e.data     = wb_data;
        in_e.csr_we   = wb_csr_we;
        in_e.csr_addr = wb_csr_addr;
        in_e.csr_data = wb_csr_data;
    end

    assign useful   = wb_valid && ((wb_rd_we && (wb_rd != 5'd0)) || wb_csr_we);
    assign full     = (count == (PW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign overflow = ovf_q;

    // Dequeue whenever ports are free and something is queued. Enqueue while
    // blocked (if room), or behind a draining head so order is preserved;
    // an unblocked input to an empty buffer passes straight through instead.
    assign deq = !block && !empty;
    assign enq = useful && (block ? !full : !empty);

    // Queue bookkeeping: pointers, occupancy, valid bits and sticky overflow.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            vld   <= '0;
            ovf_q <= 1'b0;
        end else begin
            if (deq) begin
                vld[head] <= 1'b0;
                head      <= head + 1'b1;
            end
            // At full with a simultaneous dequeue, head == tail: set wins.
            if (enq) begin
                vld[tail] <= 1'b1;
                tail      <= tail + 1'b1;
            end
            case ({enq, deq})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (useful && full && block)
                ovf_q <= 1'b1;
        end
    end

    // Entry payload storage; validity is tracked separately so no reset needed.
    always_ff @(posedge clk) begin
        if (enq)
            mem[tail] <= in_e;
    end

    // Write-port mux: head entry when queued, else pass-through; zero when idle.
    always_comb begin
        entry_t src;
        logic   act;
        src       = empty ? in_e : mem[head];
        act       = rst && !block && (empty ? useful : 1'b1);
        rf_we     = act && src.rd_we;
        rf_addr   = rf_we ? src.rd : 5'd0;
        rf_wdata  = rf_we ? src.data : 64'd0;
        csr_we    = act && src.csr_we;
        csr_addr  = csr_we ? src.csr_addr : 12'd0;
        csr_wdata = csr_we ? src.csr_data : 64'd0;
    end

    // Forwarding: walk head to tail so the youngest matching entry wins.
    always_comb begin
        logic [PW-1:0] idx;
        idx      = '0;
        rs1_hit  = 1'b0;
        rs2_hit  = 1'b0;
        rs1_data = 64'd0;
        rs2_data = 64'd0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PW'(i);
            if (vld[idx] && mem[idx].rd_we) begin
                if (rs1_addr != 5'd0 && mem[idx].rd == rs1_addr) begin
                    rs1_hit  = 1'b1;
                    rs1_data = mem[idx].data;
                end
                if (rs2_addr != 5'd0 && mem[idx].rd == rs2_addr) begin
                    rs2_hit  = 1'b1;
                    rs2_data = mem[idx].data;
                end
            end
        end
    end

endmodule

// File: tb/tb_wb_drain.sv
// Directed bench for wb_drain with an in-order scoreboard of expected writes.
module tb_wb_drain;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        wb_valid, wb_rd_we, wb_csr_we, block;
    logic [4:0]  wb_rd, rs1_addr, rs2_addr;
    logic [63:0] wb_data, wb_csr_data;
    logic [11:0] wb_csr_addr;
    logic        rf_we, csr_we, rs1_hit, rs2_hit, full, empty, overflow;
    logic [4:0]  rf_addr;
    logic [63:0] rf_wdata, csr_wdata, rs1_data, rs2_data;
    logic [11:0] csr_addr;

    typedef struct {
        logic        rf_we;
        logic [4:0]  a;
        logic [63:0] d;
        logic        cwe;
        logic [11:0] ca;
        logic [63:0] cd;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    wb_drain #(.DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_rd_we(wb_rd_we), .wb_data(wb_data),
        .wb_csr_we(wb_csr_we), .wb_csr_addr(wb_csr_addr), .wb_csr_data(wb_csr_data),
        .block(block),
        .rf_we(rf_we), .rf_addr(rf_addr), .rf_wdata(rf_wdata),
        .csr_we(csr_we), .csr_addr(csr_addr), .csr_wdata(csr_wdata),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_hit(rs1_hit), .rs2_hit(rs2_hit), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .full(full), .empty(empty), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        wb_valid = 0; wb_rd = 0; wb_rd_we = 0; wb_data = 0;
        wb_csr_we = 0; wb_csr_addr = 0; wb_csr_data = 0;
    endtask

    // Present one writeback; optionally record the write it should produce.
    task automatic wb(input logic [4:0] rd, input logic [63:0] d, input logic cwe,
                      input logic [11:0] ca, input logic [63:0] cd, input bit push);
        exp_t e;
        wb_valid = 1; wb_rd = rd; wb_rd_we = 1; wb_data = d;
        wb_csr_we = cwe; wb_csr_addr = ca; wb_csr_data = cd;
        if (push) begin
            e.rf_we = (rd != 0);
            e.a     = (rd != 0) ? rd : 5'd0;
            e.d     = (rd != 0) ? d : 64'd0;
            e.cwe   = cwe;
            e.ca    = cwe ? ca : 12'd0;
            e.cd    = cwe ? cd : 64'd0;
            sb.push_back(e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every emitted write must match the oldest expected one.
    always @(negedge clk) begin
        if (rst) begin
            if (rf_we || csr_we) begin
                if (sb.size() == 0) begin
                    chk("unexpected_write", 64'({rf_we, rf_addr}), 64'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("sb_rf_we", rf_we, e.rf_we);
                    chk("sb_rf_addr", rf_addr, e.a);
                    chk("sb_rf_wdata", rf_wdata, e.d);
                    chk("sb_csr_we", csr_we, e.cwe);
                    chk("sb_csr_addr", csr_addr, e.ca);
                    chk("sb_csr_wdata", csr_wdata, e.cd);
                end
            end else begin
                chk("idle_zero", 64'(rf_addr) | rf_wdata | 64'(csr_addr) | csr_wdata, 64'd0);
            end
        end
    end

    initial begin
        idle();
        block = 0; rs1_addr = 0; rs2_addr = 0;

        // Reset state, with a live input that must not pass through.
        wb(5'd3, 64'h12, 1'b0, 12'h0, 64'h0, 1'b0);
        #2;
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_rf_we", rf_we, 0);
        chk("rst_csr_we", csr_we, 0);
        chk("rst_rs1_hit", rs1_hit, 0);
        idle();
        @(posedge clk); #1 rst = 1;

        // Pass-through with zero latency.
        wb(5'd5, 64'hAA, 1'b0, 12'h0, 64'h0, 1'b1);
        #1;
        chk("pt_rf_we", rf_we, 1);
        chk("pt_rf_addr", rf_addr, 5);
        chk("pt_rf_wdata", rf_wdata, 64'hAA);
        chk("pt_empty", empty, 1);
        tick();
        chk("pt_empty_after", empty, 1);

        // x0 GPR-only write is a bubble.
        wb(5'd0, 64'h55, 1'b0, 12'h0, 64'h0, 1'b0);
        #1 chk("x0_rf_we", rf_we, 0);
        tick();
        chk("x0_empty", empty, 1);

        // Queue three while blocked, then drain in consecutive cycles.
        block = 1;
        for (int i = 1; i <= 3; i++) begin
            wb(5'(i), 64'(i * 'h11), 1'b0, 12'h0, 64'h0, 1'b1);
            #1 chk("blocked_rf_we", rf_we, 0);
            tick();
        end
        idle();
        block = 0;
        for (int i = 1; i <= 3; i++) begin
            #1 chk("drain_addr", rf_addr, 5'(i));
            tick();
        end
        chk("drain_empty", empty, 1);

        // Forwarding picks the youngest matching entry.
        block = 1;
        wb(5'd7, 64'h1, 1'b0, 12'h0, 64'h0, 1'b1); tick();
        wb(5'd7, 64'h2, 1'b0, 12'h0, 64'h0, 1'b1); tick();
        idle();
        rs1_addr = 7; rs2_addr = 0;
        #1;
        chk("fwd_rs1_hit", rs1_hit, 1);
        chk("fwd_rs1_data", rs1_data, 64'h2);
        chk("fwd_rs2_hit", rs2_hit, 0);
        chk("fwd_rs2_data", rs2_data, 0);
        block = 0;
        #1 chk("fwd_during_deq", rs1_data, 64'h2);
        tick();
        tick();
        chk("fwd_empty", empty, 1);
        chk("fwd_gone", rs1_hit, 0);
        rs1_addr = 0;

        // Fill, then overflow while blocked.
        block = 1;
        for (int i = 0; i < 4; i++) begin
            wb(5'(10 + i), 64'('hA0 + i), 1'b0, 12'h0, 64'h0, 1'b1);
            tick();
            if (i == 2) chk("not_full_at_3", full, 0);
        end
        chk("full_at_4", full, 1);
        chk("ovf_before", overflow, 0);
        wb(5'd14, 64'hEE, 1'b0, 12'h0, 64'h0, 1'b0);
        tick();
        chk("ovf_set", overflow, 1);
        chk("ovf_full", full, 1);
        idle();
        block = 0;
        repeat (4) tick();
        chk("ovf_sticky", overflow, 1);
        chk("ovf_drained", empty, 1);

        // Simultaneous enqueue/dequeue at full.
        block = 1;
        for (int i = 0; i < 4; i++) begin
            wb(5'(16 + i), 64'('hB0 + i), 1'b0, 12'h0, 64'h0, 1'b1);
            tick();
        end
        chk("sim_full", full, 1);
        block = 0;
        wb(5'd9, 64'h99, 1'b0, 12'h0, 64'h0, 1'b1);
        #1 chk("sim_head", rf_addr, 16);
        tick();
        chk("sim_still_full", full, 1);
        idle();
        repeat (4) tick();
        chk("sim_empty", empty, 1);

        // CSR write targeting x0 passes through with rf_we low.
        wb(5'd0, 64'h77, 1'b1, 12'h300, 64'h8, 1'b1);
        #1;
        chk("csr_we", csr_we, 1);
        chk("csr_addr", csr_addr, 12'h300);
        chk("csr_rf_we", rf_we, 0);
        tick();
        chk("csr_empty", empty, 1);

        // Reset mid-drain discards pending entries.
        block = 1;
        for (int i = 0; i < 3; i++) begin
            wb(5'(20 + i), 64'('hC0 + i), 1'b0, 12'h0, 64'h0, 1'b1);
            tick();
        end
        idle();
        block = 0;
        rs1_addr = 21;
        tick();
        #2 rst = 0;
        sb.delete();
        #1;
        chk("mid_rst_empty", empty, 1);
        chk("mid_rst_full", full, 0);
        chk("mid_rst_rf_we", rf_we, 0);
        chk("mid_rst_rs1_hit", rs1_hit, 0);
        @(posedge clk); #1 rst = 1;
        repeat (3) tick();
        chk("post_rst_empty", empty, 1);

        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
